// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the MIPS ID/EX stage:
//                ALU control encodings, datapath width defaults and the
//                registered control bundle with its bubble value.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Datapath width defaults
    localparam int DATA_W_DEFAULT   = 32;
    localparam int REG_W_DEFAULT    = 5;
    localparam int ALUCTL_W_DEFAULT = 4;

    // ALU control encodings understood by MIPS_ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Single-bit control carried from ID into EX
    typedef struct packed {
        logic valid;
        logic alu_src;
        logic reg_dst;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    // A bubble is an invalid slot with every side effect disabled
    localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_forward_unit
//  Description : Selects the freshest value for one EX source register,
//                preferring EX/MEM over MEM/WB over the latched RF data.
//                Register $0 is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_forward_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0]  src_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_W-1:0]  exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_W-1:0]  memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    input  logic [DATA_W-1:0] default_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_reg_i);
    assign w_memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_reg_i);

    // Younger producer (EX/MEM) wins over older one (MEM/WB)
    always_comb begin
        if (w_exmem_hit)      data_o = exmem_result_i;
        else if (w_memwb_hit) data_o = memwb_result_i;
        else                  data_o = default_data_i;
    end

endmodule : mips_forward_unit
`default_nettype wire

// File: rtl/mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mips_id_ex_stage
//  Description : ID/EX pipeline register with flush/stall/load-use bubble
//                insertion and combinational EX operand forwarding feeding
//                MIPS_ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int REG_W    = REG_W_DEFAULT,
    parameter int ALUCTL_W = ALUCTL_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                id_valid_i,
    input  logic [DATA_W-1:0]   id_rs_data_i,
    input  logic [DATA_W-1:0]   id_rt_data_i,
    input  logic [DATA_W-1:0]   id_imm_i,
    input  logic [REG_W-1:0]    id_rs_i,
    input  logic [REG_W-1:0]    id_rt_i,
    input  logic [REG_W-1:0]    id_rd_i,
    input  logic                id_uses_rt_i,
    input  logic [ALUCTL_W-1:0] id_alu_ctl_i,
    input  logic                id_alu_src_i,
    input  logic                id_reg_dst_i,
    input  logic                id_reg_write_i,
    input  logic                id_mem_read_i,
    input  logic                id_mem_write_i,
    input  logic                id_mem_to_reg_i,
    input  logic                exmem_reg_write_i,
    input  logic [REG_W-1:0]    exmem_rd_i,
    input  logic [DATA_W-1:0]   exmem_result_i,
    input  logic                memwb_reg_write_i,
    input  logic [REG_W-1:0]    memwb_rd_i,
    input  logic [DATA_W-1:0]   memwb_result_i,
    output logic                hazard_stall_o,
    output logic                ex_valid_o,
    output logic [DATA_W-1:0]   alu_a_o,
    output logic [DATA_W-1:0]   alu_b_o,
    output logic [ALUCTL_W-1:0] alu_ctl_o,
    output logic [DATA_W-1:0]   store_data_o,
    output logic [REG_W-1:0]    write_reg_o,
    output logic                ex_reg_write_o,
    output logic                ex_mem_read_o,
    output logic                ex_mem_write_o,
    output logic                ex_mem_to_reg_o
);

    ex_ctrl_t            ctrl_q,    ctrl_d;
    logic [ALUCTL_W-1:0] alu_ctl_q, alu_ctl_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d;
    logic [DATA_W-1:0]   rt_data_q, rt_data_d;
    logic [DATA_W-1:0]   imm_q,     imm_d;
    logic [REG_W-1:0]    rs_q,      rs_d;
    logic [REG_W-1:0]    rt_q,      rt_d;
    logic [REG_W-1:0]    rd_q,      rd_d;

    logic                w_load_use;
    logic                w_bubble;
    logic                w_load;
    logic [DATA_W-1:0]   w_fwd_a;
    logic [DATA_W-1:0]   w_fwd_b;

    // A load in EX whose rt is needed by the instruction in ID cannot be
    // forwarded in time; the consumer must wait one cycle.
    assign w_load_use = ctrl_q.valid && ctrl_q.mem_read && (rt_q != '0) &&
                        ((rt_q == id_rs_i) || (id_uses_rt_i && (rt_q == id_rt_i)));

    // Flush beats stall; stall beats the load-use bubble
    assign w_bubble = flush_i || (!stall_i && w_load_use);
    assign w_load   = !flush_i && !stall_i && !w_load_use;

    // Next-state selection: bubble, hold or capture the decode slot
    always_comb begin
        ctrl_d    = ctrl_q;
        alu_ctl_d = alu_ctl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        if (w_bubble) begin
            ctrl_d    = BUBBLE_CTRL;
            alu_ctl_d = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
        end else if (w_load) begin
            ctrl_d.valid      = id_valid_i;
            ctrl_d.alu_src    = id_alu_src_i;
            ctrl_d.reg_dst    = id_reg_dst_i;
            ctrl_d.reg_write  = id_reg_write_i && id_valid_i;
            ctrl_d.mem_read   = id_mem_read_i  && id_valid_i;
            ctrl_d.mem_write  = id_mem_write_i && id_valid_i;
            ctrl_d.mem_to_reg = id_mem_to_reg_i;
            alu_ctl_d         = id_alu_ctl_i;
            rs_data_d         = id_rs_data_i;
            rt_data_d         = id_rt_data_i;
            imm_d             = id_imm_i;
            rs_d              = id_rs_i;
            rt_d              = id_rt_i;
            rd_d              = id_rd_i;
        end
    end

    // ID/EX register bank with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= BUBBLE_CTRL;
            alu_ctl_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            alu_ctl_q <= alu_ctl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    mips_forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src_reg_i         (rs_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_result_i    (memwb_result_i),
        .default_data_i    (rs_data_q),
        .data_o            (w_fwd_a)
    );

    mips_forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src_reg_i         (rt_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_result_i    (memwb_result_i),
        .default_data_i    (rt_data_q),
        .data_o            (w_fwd_b)
    );

    assign hazard_stall_o  = w_load_use;
    assign ex_valid_o      = ctrl_q.valid;
    assign alu_a_o         = w_fwd_a;
    assign alu_b_o         = ctrl_q.alu_src ? imm_q : w_fwd_b;
    assign alu_ctl_o       = alu_ctl_q;
    assign store_data_o    = w_fwd_b;
    assign write_reg_o     = ctrl_q.reg_dst ? rd_q : rt_q;
    assign ex_reg_write_o  = ctrl_q.reg_write;
    assign ex_mem_read_o   = ctrl_q.mem_read;
    assign ex_mem_write_o  = ctrl_q.mem_write;
    assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;

endmodule : mips_id_ex_stage
`default_nettype wire

// File: tb/tb_mips_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_id_ex_stage
//  Description : Self-checking bench for mips_id_ex_stage: directed scenarios
//                plus randomized traffic against a behavioural slot model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_ctl;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;

    logic        hazard_stall, ex_valid;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_ctl;
    logic [4:0]  write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mips_id_ex_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .flush_i          (flush),
        .id_valid_i       (id_valid),
        .id_rs_data_i     (id_rs_data),
        .id_rt_data_i     (id_rt_data),
        .id_imm_i         (id_imm),
        .id_rs_i          (id_rs),
        .id_rt_i          (id_rt),
        .id_rd_i          (id_rd),
        .id_uses_rt_i     (id_uses_rt),
        .id_alu_ctl_i     (id_alu_ctl),
        .id_alu_src_i     (id_alu_src),
        .id_reg_dst_i     (id_reg_dst),
        .id_reg_write_i   (id_reg_write),
        .id_mem_read_i    (id_mem_read),
        .id_mem_write_i   (id_mem_write),
        .id_mem_to_reg_i  (id_mem_to_reg),
        .exmem_reg_write_i(exmem_reg_write),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_reg_write_i(memwb_reg_write),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .hazard_stall_o   (hazard_stall),
        .ex_valid_o       (ex_valid),
        .alu_a_o          (alu_a),
        .alu_b_o          (alu_b),
        .alu_ctl_o        (alu_ctl),
        .store_data_o     (store_data),
        .write_reg_o      (write_reg),
        .ex_reg_write_o   (ex_reg_write),
        .ex_mem_read_o    (ex_mem_read),
        .ex_mem_write_o   (ex_mem_write),
        .ex_mem_to_reg_o  (ex_mem_to_reg)
    );

    // ---------------- behavioural model of the EX slot ----------------
    typedef struct packed {
        logic        valid, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
        logic [3:0]  alu_ctl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } slot_t;

    slot_t m;

    function automatic logic model_hazard(slot_t s);
        if (!(s.valid && s.mem_read) || s.rt == 5'd0) return 1'b0;
        if (s.rt == id_rs) return 1'b1;
        return id_uses_rt && (s.rt == id_rt);
    endfunction

    function automatic slot_t decode_slot();
        slot_t s;
        s.valid      = id_valid;
        s.alu_src    = id_alu_src;
        s.reg_dst    = id_reg_dst;
        s.reg_write  = id_valid ? id_reg_write : 1'b0;
        s.mem_read   = id_valid ? id_mem_read  : 1'b0;
        s.mem_write  = id_valid ? id_mem_write : 1'b0;
        s.mem_to_reg = id_mem_to_reg;
        s.alu_ctl    = id_alu_ctl;
        s.rs_data    = id_rs_data;
        s.rt_data    = id_rt_data;
        s.imm        = id_imm;
        s.rs         = id_rs;
        s.rt         = id_rt;
        s.rd         = id_rd;
        return s;
    endfunction

    // Value an EX reader of register idx should see
    function automatic logic [31:0] freshest(logic [4:0] idx, logic [31:0] rf_val);
        if (idx == 5'd0) return rf_val;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return rf_val;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  m <= '0;
        else if (flush)              m <= '0;
        else if (stall)              m <= m;
        else if (model_hazard(m))    m <= '0;
        else                         m <= decode_slot();
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] fb;
        fb = freshest(m.rt, m.rt_data);
        check_eq({tag, ".hazard"},   32'(hazard_stall),  32'(model_hazard(m)));
        check_eq({tag, ".valid"},    32'(ex_valid),      32'(m.valid));
        check_eq({tag, ".alu_a"},    alu_a,              freshest(m.rs, m.rs_data));
        check_eq({tag, ".alu_b"},    alu_b,              m.alu_src ? m.imm : fb);
        check_eq({tag, ".store"},    store_data,         fb);
        check_eq({tag, ".alu_ctl"},  32'(alu_ctl),       32'(m.alu_ctl));
        check_eq({tag, ".wreg"},     32'(write_reg),     32'(m.reg_dst ? m.rd : m.rt));
        check_eq({tag, ".ctl"},
                 {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                 {28'd0, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg});
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_ctl = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rtype(input logic [3:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        id_valid = 1; id_uses_rt = 1; id_alu_ctl = ctl; id_alu_src = 0; id_reg_dst = 1;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b; id_imm = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #12;
        // reset state
        check_eq("rst.valid",   32'(ex_valid),     32'd0);
        check_eq("rst.alu_ctl", 32'(alu_ctl),      32'd0);
        check_eq("rst.wreg",    32'(write_reg),    32'd0);
        check_eq("rst.hazard",  32'(hazard_stall), 32'd0);
        check_eq("rst.ctl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        rst_n = 1;
        tick();

        // load add
        set_rtype(4'b0010, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20);
        tick();
        check_eq("add.alu_a",   alu_a,          32'd10);
        check_eq("add.alu_b",   alu_b,          32'd20);
        check_eq("add.alu_ctl", 32'(alu_ctl),   32'h2);
        check_eq("add.valid",   32'(ex_valid),  32'd1);
        check_eq("add.wreg",    32'(write_reg), 32'd3);
        check_all("add");

        // EX/MEM has priority over MEM/WB
        set_rtype(4'b0010, 5'd8, 5'd4, 5'd5, 32'd1, 32'd2);
        tick();
        exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h55;
        memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h66;
        #1;
        check_eq("fwd.prio", alu_a, 32'h55);
        exmem_reg_write = 0;
        #1;
        check_eq("fwd.memwb", alu_a, 32'h66);
        check_all("fwd");
        clear_inputs();

        // $0 is never forwarded
        set_rtype(4'b0001, 5'd3, 5'd0, 5'd6, 32'd4, 32'd0);
        tick();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEE;
        #1;
        check_eq("zero.alu_b", alu_b,      32'd0);
        check_eq("zero.store", store_data, 32'd0);
        clear_inputs();

        // load-use: lw $9 in EX, add using $9 in ID
        id_valid = 1; id_alu_ctl = 4'b0010; id_alu_src = 1; id_reg_write = 1;
        id_mem_read = 1; id_mem_to_reg = 1; id_rs = 5'd2; id_rt = 5'd9; id_imm = 32'd4;
        tick();
        set_rtype(4'b0010, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'd3);
        #1;
        check_eq("lu.hazard", 32'(hazard_stall), 32'd1);
        tick();
        check_eq("lu.bubble_valid", 32'(ex_valid),     32'd0);
        check_eq("lu.bubble_rw",    32'(ex_reg_write), 32'd0);
        check_eq("lu.clear",        32'(hazard_stall), 32'd0);
        tick();
        memwb_reg_write = 1; memwb_rd = 9; memwb_result = 32'h1234;
        #1;
        check_eq("lu.retry_valid", 32'(ex_valid), 32'd1);
        check_eq("lu.retry_fwd",   alu_a,         32'h1234);
        check_all("lu");
        clear_inputs();

        // flush wins over stall
        set_rtype(4'b0010, 5'd1, 5'd2, 5'd3, 32'd7, 32'd8);
        tick();
        set_rtype(4'b0110, 5'd4, 5'd5, 5'd6, 32'd9, 32'd1);
        flush = 1; stall = 1;
        tick();
        check_eq("flush.valid",   32'(ex_valid), 32'd0);
        check_eq("flush.alu_ctl", 32'(alu_ctl),  32'd0);
        clear_inputs();

        // stall holds for 3 cycles while ID changes
        set_rtype(4'b0111, 5'd12, 5'd13, 5'd14, 32'd100, 32'd200);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_rtype(4'b0001, 5'(i + 1), 5'd2, 5'd20, 32'(i), 32'd5);
            tick();
            check_eq("stall.alu_ctl", 32'(alu_ctl),   32'h7);
            check_eq("stall.wreg",    32'(write_reg), 32'd14);
            check_eq("stall.alu_a",   alu_a,          32'd100);
            check_eq("stall.valid",   32'(ex_valid),  32'd1);
        end

        // asynchronous reset during a stall
        #2;
        rst_n = 0;
        #1;
        check_eq("arst.valid",   32'(ex_valid),  32'd0);
        check_eq("arst.alu_ctl", 32'(alu_ctl),   32'd0);
        check_eq("arst.wreg",    32'(write_reg), 32'd0);
        rst_n = 1;
        clear_inputs();
        tick();

        // immediate path
        set_rtype(4'b0010, 5'd1, 5'd7, 5'd0, 32'd3, 32'd7);
        id_alu_src = 1; id_reg_dst = 0; id_imm = 32'hFFFF_FFF0;
        tick();
        check_eq("imm.alu_b", alu_b,          32'hFFFF_FFF0);
        check_eq("imm.store", store_data,     32'd7);
        check_eq("imm.wreg",  32'(write_reg), 32'd7);
        check_all("imm");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall           = ($urandom_range(0, 4) == 0);
            flush           = ($urandom_range(0, 7) == 0);
            id_valid        = ($urandom_range(0, 5) != 0);
            id_uses_rt      = 1'($urandom);
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            id_imm          = $urandom;
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_rd           = 5'($urandom_range(0, 31));
            id_alu_ctl      = 4'($urandom);
            id_alu_src      = 1'($urandom);
            id_reg_dst      = 1'($urandom);
            id_reg_write    = 1'($urandom);
            id_mem_read     = 1'($urandom);
            id_mem_write    = 1'($urandom);
            id_mem_to_reg   = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_result    = $urandom;
            #1;
            check_all("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mips_id_ex_stage
`default_nettype wire

// File: doc/mips_id_ex_stage.md
Name: mips_id_ex_stage

Overview:
ID/EX pipeline register plus EX-stage operand forwarding. It feeds MIPS_ALU directly, driving its A, B and ALUControl inputs.
- Captures decoded operands and control from the decode stage.
- Inserts bubbles on flush or load-use hazard.
- Holds its contents on an external stall.
- Selects forwarded operands from EX/MEM and MEM/WB.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-index width
ALUCTL_W, 4, ALU control width (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all ID/EX contents this cycle
flush  in  1  replace ID/EX contents with a bubble (branch/jump redirect)
id_valid  in  1  decode slot holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W  register indices
id_uses_rt  in  1  instruction reads rt as a source (R-type, sw, beq)
id_alu_ctl  in  ALUCTL_W  ALU operation
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
exmem_reg_write  in  1  EX/MEM will write the register file
exmem_rd  in  REG_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB will write the register file
memwb_rd  in  REG_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB write-back value
hazard_stall  out  1  load-use detected; IF/ID and PC must hold
ex_valid  out  1  EX slot holds a real instruction
alu_a, alu_b  out  DATA_W  to MIPS_ALU A, B
alu_ctl  out  ALUCTL_W  to MIPS_ALU ALUControl
store_data  out  DATA_W  forwarded rt value for sw
write_reg  out  REG_W  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control bits

Behaviour:
- Reset (rst_n=0, asynchronous): all registers zero. Consequences: ex_valid=0, alu_ctl=0000, all control outputs 0, write_reg=0, hazard_stall=0. The data outputs alu_a, alu_b and store_data are combinational over the forwarding inputs and are not forced to zero.
- Rising-edge update priority: reset > flush > stall > hazard_stall > load.
- Flush: load a bubble. A bubble zeroes every register: ex_valid=0, all control 0, alu_ctl=0000.
- Stall=1 (and no flush): hold all registers unchanged.
- hazard_stall=1 (no flush, no stall): load a bubble. The instruction in ID is retried next cycle because upstream holds.
- Otherwise load all id_* fields. Gate control with id_valid: when id_valid=0, reg_write, mem_read and mem_write are loaded as 0.
- hazard_stall (combinational) = ex_valid & ex_mem_read & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)), where ex_rt is the registered rt index.
- Forward A (on registered rs), in priority order:
  - exmem_reg_write & exmem_rd≠0 & exmem_rd==ex_rs → exmem_result
  - else memwb_reg_write & memwb_rd≠0 & memwb_rd==ex_rs → memwb_result
  - else registered rs_data
- Forward rt: same rule on ex_rt, producing fwd_b.
- Operand outputs:
  - alu_a = forward A
  - store_data = fwd_b
  - alu_b = ex_alu_src ? ex_imm : fwd_b
- write_reg = ex_reg_dst ? ex_rd : ex_rt.
- Latency: one cycle from ID inputs to registered EX fields. Forwarding adds no cycles; it is combinational within EX.
- Register $0 is never forwarded, even when a writer targets it.
- Reset mid-stall: state clears immediately, with no dependence on clk.

Decomposition:
- Shared package mips_pkg holds:
  - ALU control constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111
  - DATA_W and REG_W defaults
  - a bubble-control constant
- One combinational sub-module, mips_forward_unit. It takes the register index, the EX/MEM and MEM/WB write info, and the default data, and returns the selected data. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset, then load add: rs_data=10, rt_data=20, alu_ctl=0010, alu_src=0 → next cycle alu_a=10, alu_b=20, alu_ctl=0010, ex_valid=1.
- EX/MEM forward: ex_rs=8, exmem_rd=8, exmem_reg_write=1, exmem_result=0x55; MEM/WB also rd=8 with 0x66 → alu_a=0x55 (EX/MEM priority).
- $0 guard: ex_rt=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF, registered rt_data=0 → alu_b=0.
- Load-use: EX holds lw with rt=9; ID has add with rs=9 → hazard_stall=1; next edge ex_valid=0, ex_reg_write=0; following cycle the add is loaded and alu_a is forwarded from memwb_result.
- Flush and stall together while ID holds sub with alu_ctl=0110 → bubble loaded (ex_valid=0, alu_ctl=0000). Stall alone holds prior values for 3 cycles unchanged.
- Immediate path: alu_src=1, id_imm=0xFFFFFFF0, rt_data=7 → alu_b=0xFFFFFFF0, store_data=7.
